// File: rtl/read_buffer_if.sv
// Bus between the CPU read port and the read_buffer. It carries the live DMA counters,
// the read/clear strobes, and the registered byte-return signals.
interface read_buffer_if #(
    parameter int NUM_CH = 4
);
    logic [16*NUM_CH-1:0] cur_addr;
    logic [16*NUM_CH-1:0] cur_wc;
    logic                 rd_req;
    logic [2:0]           ch_sel;
    logic                 reg_sel;
    logic                 clr_ff;
    logic [7:0]           data_bus_out;
    logic                 data_oe;
    logic                 byte_ptr;
    logic                 read_done;
    logic                 seq_err;

    modport master (
        output cur_addr, cur_wc, rd_req, ch_sel, reg_sel, clr_ff,
        input  data_bus_out, data_oe, byte_ptr, read_done, seq_err
    );

    modport slave (
        input  cur_addr, cur_wc, rd_req, ch_sel, reg_sel, clr_ff,
        output data_bus_out, data_oe, byte_ptr, read_done, seq_err
    );
endinterface

// File: rtl/read_buffer.sv
// Byte-serialising DMA counter read path. The high byte is returned first, and a 16-bit
// snapshot is taken on that first byte so the low byte comes from the same instant.
//
// state   | meaning
// ST_HIGH | byte pointer = 0, next read returns the live high byte and snapshots
// ST_LOW  | byte pointer = 1, next read returns the low byte of the snapshot
module read_buffer #(
    parameter int NUM_CH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    read_buffer_if.slave bus
);
    typedef enum logic {
        ST_HIGH = 1'b0,
        ST_LOW  = 1'b1
    } state_t;

    state_t      r_state;
    logic [15:0] r_hold;
    logic [3:0]  r_tag;
    logic [7:0]  r_data;
    logic        r_oe;
    logic        r_done;
    logic        r_err;

    state_t      w_state_nxt;
    logic [15:0] w_hold_nxt;
    logic [3:0]  w_tag_nxt;
    logic [7:0]  w_data_nxt;
    logic        w_oe_nxt;
    logic        w_done_nxt;
    logic        w_err_nxt;
    logic [15:0] w_sel_val;
    logic [3:0]  w_req_tag;

    assign w_req_tag = {bus.ch_sel, bus.reg_sel};

    // Out-of-range channel numbers match no channel and so read as zero.
    always_comb begin
        w_sel_val = 16'h0000;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.ch_sel == 3'(i)) begin
                w_sel_val = bus.reg_sel ? bus.cur_wc[16*i +: 16] : bus.cur_addr[16*i +: 16];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_HIGH;
            r_hold  <= 16'h0000;
            r_tag   <= 4'h0;
            r_data  <= 8'h00;
            r_oe    <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            r_tag   <= w_tag_nxt;
            r_data  <= w_data_nxt;
            r_oe    <= w_oe_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // A clear in the same cycle as a read turns that read into a first-byte read.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_tag_nxt   = r_tag;
        w_data_nxt  = r_data;
        w_oe_nxt    = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        if (bus.clr_ff) begin
            w_state_nxt = ST_HIGH;
        end
        if (bus.rd_req) begin
            w_oe_nxt = 1'b1;
            if (r_state == ST_LOW && !bus.clr_ff) begin
                w_data_nxt  = r_hold[7:0];
                w_done_nxt  = 1'b1;
                w_err_nxt   = (w_req_tag != r_tag);
                w_state_nxt = ST_HIGH;
            end else begin
                w_hold_nxt  = w_sel_val;
                w_tag_nxt   = w_req_tag;
                w_data_nxt  = w_sel_val[15:8];
                w_state_nxt = ST_LOW;
            end
        end
    end

    assign bus.data_bus_out = r_data;
    assign bus.data_oe      = r_oe;
    assign bus.byte_ptr     = (r_state == ST_LOW);
    assign bus.read_done    = r_done;
    assign bus.seq_err      = r_err;
endmodule

// File: tb/tb_read_buffer.sv
// Directed-vector bench for read_buffer: a table of single-cycle records plus a short
// hand-written back-to-back sequence with live counters moving between the bytes.
module tb_read_buffer;
    localparam int NUM_CH = 4;

    typedef struct {
        logic        rst;
        logic        rd;
        logic        clr;
        logic [2:0]  ch;
        logic        rs;
        logic        wr;
        logic [15:0] wval;
        logic [7:0]  e_data;
        logic        e_oe;
        logic        e_done;
        logic        e_err;
        logic        e_ptr;
    } vec_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    vec_t vecs [22];

    read_buffer_if #(.NUM_CH(NUM_CH)) bus ();

    read_buffer #(.NUM_CH(NUM_CH)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input int idx, input string name, input logic [7:0] got, input logic [7:0] exp);
        if (got !== exp) begin
            $display("FAIL vec%0d %s got %h want %h", idx, name, got, exp);
            n_err++;
        end
    endtask

    task automatic apply(input int idx, input vec_t v);
        @(negedge clk);
        if (v.wr) begin
            if (v.rs) bus.cur_wc[16*v.ch +: 16] = v.wval;
            else      bus.cur_addr[16*v.ch +: 16] = v.wval;
        end
        rst         = v.rst;
        bus.rd_req  = v.rd;
        bus.clr_ff  = v.clr;
        bus.ch_sel  = v.ch;
        bus.reg_sel = v.rs;
        @(posedge clk);
        #1;
        n_vec++;
        chk(idx, "data_bus_out", bus.data_bus_out, v.e_data);
        chk(idx, "data_oe",      {7'd0, bus.data_oe},   {7'd0, v.e_oe});
        chk(idx, "read_done",    {7'd0, bus.read_done}, {7'd0, v.e_done});
        chk(idx, "seq_err",      {7'd0, bus.seq_err},   {7'd0, v.e_err});
        chk(idx, "byte_ptr",     {7'd0, bus.byte_ptr},  {7'd0, v.e_ptr});
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus.cur_addr = '0;
        bus.cur_wc   = '0;
        bus.rd_req   = 1'b0;
        bus.clr_ff   = 1'b0;
        bus.ch_sel   = 3'd0;
        bus.reg_sel  = 1'b0;

        //          rst  rd   clr  ch    rs   wr   wval      data   oe   done err  ptr
        vecs[0]  = '{1'b1,1'b0,1'b0,3'd0,1'b0,1'b0,16'h0000, 8'h00,1'b0,1'b0,1'b0,1'b0};
        vecs[1]  = '{1'b0,1'b1,1'b0,3'd2,1'b0,1'b1,16'hA55A, 8'hA5,1'b1,1'b0,1'b0,1'b1};
        vecs[2]  = '{1'b0,1'b0,1'b0,3'd2,1'b0,1'b0,16'h0000, 8'hA5,1'b0,1'b0,1'b0,1'b1};
        vecs[3]  = '{1'b0,1'b1,1'b0,3'd2,1'b0,1'b0,16'h0000, 8'h5A,1'b1,1'b1,1'b0,1'b0};
        vecs[4]  = '{1'b0,1'b1,1'b0,3'd1,1'b1,1'b1,16'h01FF, 8'h01,1'b1,1'b0,1'b0,1'b1};
        vecs[5]  = '{1'b0,1'b0,1'b0,3'd1,1'b1,1'b1,16'h0200, 8'h01,1'b0,1'b0,1'b0,1'b1};
        vecs[6]  = '{1'b0,1'b1,1'b0,3'd1,1'b1,1'b0,16'h0000, 8'hFF,1'b1,1'b1,1'b0,1'b0};
        vecs[7]  = '{1'b0,1'b1,1'b0,3'd0,1'b0,1'b1,16'h1234, 8'h12,1'b1,1'b0,1'b0,1'b1};
        vecs[8]  = '{1'b0,1'b0,1'b1,3'd0,1'b0,1'b0,16'h0000, 8'h12,1'b0,1'b0,1'b0,1'b0};
        vecs[9]  = '{1'b0,1'b1,1'b0,3'd0,1'b0,1'b0,16'h0000, 8'h12,1'b1,1'b0,1'b0,1'b1};
        vecs[10] = '{1'b0,1'b1,1'b1,3'd3,1'b0,1'b1,16'hBEEF, 8'hBE,1'b1,1'b0,1'b0,1'b1};
        vecs[11] = '{1'b0,1'b1,1'b0,3'd3,1'b0,1'b0,16'h0000, 8'hEF,1'b1,1'b1,1'b0,1'b0};
        vecs[12] = '{1'b0,1'b1,1'b0,3'd0,1'b0,1'b1,16'h1111, 8'h11,1'b1,1'b0,1'b0,1'b1};
        vecs[13] = '{1'b0,1'b1,1'b0,3'd1,1'b1,1'b1,16'h2222, 8'h11,1'b1,1'b1,1'b1,1'b0};
        vecs[14] = '{1'b0,1'b1,1'b0,3'd0,1'b0,1'b1,16'hCAFE, 8'hCA,1'b1,1'b0,1'b0,1'b1};
        vecs[15] = '{1'b1,1'b0,1'b0,3'd0,1'b0,1'b0,16'h0000, 8'h00,1'b0,1'b0,1'b0,1'b0};
        vecs[16] = '{1'b0,1'b1,1'b0,3'd0,1'b0,1'b0,16'h0000, 8'hCA,1'b1,1'b0,1'b0,1'b1};
        vecs[17] = '{1'b0,1'b1,1'b0,3'd0,1'b0,1'b0,16'h0000, 8'hFE,1'b1,1'b1,1'b0,1'b0};
        vecs[18] = '{1'b0,1'b1,1'b0,3'd5,1'b0,1'b0,16'h0000, 8'h00,1'b1,1'b0,1'b0,1'b1};
        vecs[19] = '{1'b0,1'b1,1'b0,3'd5,1'b0,1'b0,16'h0000, 8'h00,1'b1,1'b1,1'b0,1'b0};
        vecs[20] = '{1'b1,1'b1,1'b0,3'd0,1'b0,1'b0,16'h0000, 8'h00,1'b0,1'b0,1'b0,1'b0};
        vecs[21] = '{1'b0,1'b0,1'b0,3'd0,1'b0,1'b0,16'h0000, 8'h00,1'b0,1'b0,1'b0,1'b0};

        for (int i = 0; i < 22; i++) begin
            apply(i, vecs[i]);
        end

        // Back-to-back pair on ch 3 word count while the live counter rolls over,
        // then an idle cycle checking the pulses drop and the byte is held.
        apply(100, '{1'b0,1'b1,1'b0,3'd3,1'b1,1'b1,16'h00FF, 8'h00,1'b1,1'b0,1'b0,1'b1});
        apply(101, '{1'b0,1'b1,1'b0,3'd3,1'b1,1'b1,16'h0100, 8'hFF,1'b1,1'b1,1'b0,1'b0});
        apply(102, '{1'b0,1'b0,1'b0,3'd3,1'b1,1'b0,16'h0000, 8'hFF,1'b0,1'b0,1'b0,1'b0});
        // Fresh pair straight after that, reading the rolled-over value.
        apply(103, '{1'b0,1'b1,1'b0,3'd3,1'b1,1'b0,16'h0000, 8'h01,1'b1,1'b0,1'b0,1'b1});
        apply(104, '{1'b0,1'b1,1'b0,3'd3,1'b1,1'b0,16'h0000, 8'h00,1'b1,1'b1,1'b0,1'b0});

        @(negedge clk);
        bus.rd_req = 1'b0;
        bus.clr_ff = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
